// File: rtl/adder_pkg.sv
// Shared types and elaboration helpers for the digit-serial adder family.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of digit cycles per operation; guarded so a bad DIGIT cannot divide by zero.
  function automatic int digits(input int width, input int digit);
    return (digit > 0) ? (width / digit) : 1;
  endfunction

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/digit_adder.sv
// Combinational DIGIT-bit ripple adder built from full_adder cells.
// Also exposes the carry into its top bit so the caller can derive signed overflow.
module digit_adder #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic             cout,
  output logic             cmsb
);

  logic [DIGIT:0] carry_s;

  assign carry_s[0] = cin;

  for (genvar i = 0; i < DIGIT; i++) begin : g_bit
    full_adder u_fa (
      .a   (a[i]),
      .b   (b[i]),
      .cin (carry_s[i]),
      .s   (sum[i]),
      .cout(carry_s[i+1])
    );
  end

  assign cout = carry_s[DIGIT];
  assign cmsb = carry_s[DIGIT-1];

endmodule

// File: rtl/full_adder.sv
// Single-bit full adder cell, the per-bit primitive of the digit adder.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/digit_serial_adder.sv
// Multi-cycle WIDTH-bit adder processing DIGIT bits per clock, with valid/ready
// handshakes on both sides and signed-overflow reporting.
module digit_serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             C_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             C_out,
  output logic             overflow
);

  localparam int N     = digits(WIDTH, DIGIT);
  localparam int CNT_W = cnt_w(N);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  if (WIDTH < 1 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
    $fatal(1, "digit_serial_adder: DIGIT must divide WIDTH and lie in 1..WIDTH");
  end

  state_t           state_r;
  state_t           state_nxt_s;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic [WIDTH-1:0] sum_sh_r;
  logic [WIDTH-1:0] sum_nxt_s;
  logic             carry_r;
  logic [CNT_W-1:0] cnt_r;
  logic [DIGIT-1:0] dsum_s;
  logic             dcout_s;
  logic             dcmsb_s;

  digit_adder #(.DIGIT(DIGIT)) u_digit (
    .a   (a_sh_r[DIGIT-1:0]),
    .b   (b_sh_r[DIGIT-1:0]),
    .cin (carry_r),
    .sum (dsum_s),
    .cout(dcout_s),
    .cmsb(dcmsb_s)
  );

  // New digit enters at the top; after N digits the LSB digit has reached bit 0.
  assign sum_nxt_s = (sum_sh_r >> DIGIT) | (WIDTH'(dsum_s) << (WIDTH - DIGIT));

  assign in_ready  = (state_r == IDLE);
  assign out_valid = (state_r == DONE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) state_nxt_s = RUN;
        else          state_nxt_s = IDLE;
      end
      RUN: begin
        if (cnt_r == LAST) state_nxt_s = DONE;
        else               state_nxt_s = RUN;
      end
      DONE: begin
        if (out_ready) state_nxt_s = IDLE;
        else           state_nxt_s = DONE;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Operand/sum shift registers, carry, digit counter and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_r   <= {WIDTH{1'b0}};
      b_sh_r   <= {WIDTH{1'b0}};
      sum_sh_r <= {WIDTH{1'b0}};
      carry_r  <= 1'b0;
      cnt_r    <= {CNT_W{1'b0}};
      Sum      <= {WIDTH{1'b0}};
      C_out    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            a_sh_r  <= a;
            b_sh_r  <= b;
            carry_r <= C_in;
            cnt_r   <= {CNT_W{1'b0}};
          end
        end
        RUN: begin
          a_sh_r   <= a_sh_r >> DIGIT;
          b_sh_r   <= b_sh_r >> DIGIT;
          sum_sh_r <= sum_nxt_s;
          carry_r  <= dcout_s;
          cnt_r    <= cnt_r + CNT_W'(1);
          if (cnt_r == LAST) begin
            Sum      <= sum_nxt_s;
            C_out    <= dcout_s;
            overflow <= dcmsb_s ^ dcout_s;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_digit_serial_adder.sv
// Directed, table-driven bench for digit_serial_adder in three configurations:
// 16/4 (main), 1/1 (full-adder truth table) and 8/8 (single-cycle RUN).
module tb_digit_serial_adder;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int sel    = 0;

  // 16-bit, 4-bit digits
  logic        iv16, ordy16, c16, ir16, ov16, co16, of16;
  logic [15:0] a16, b16, sum16;
  // 1-bit, 1-bit digits
  logic        iv1, ordy1, c1, ir1, ov1, co1, of1;
  logic [0:0]  a1, b1, sum1;
  // 8-bit, 8-bit digits
  logic        iv8, ordy8, c8, ir8, ov8, co8, of8;
  logic [7:0]  a8, b8, sum8;

  digit_serial_adder #(.WIDTH(16), .DIGIT(4)) u16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
    .C_in(c16), .out_valid(ov16), .out_ready(ordy16), .Sum(sum16), .C_out(co16),
    .overflow(of16));

  digit_serial_adder #(.WIDTH(1), .DIGIT(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1),
    .C_in(c1), .out_valid(ov1), .out_ready(ordy1), .Sum(sum1), .C_out(co1),
    .overflow(of1));

  digit_serial_adder #(.WIDTH(8), .DIGIT(8)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .C_in(c8), .out_valid(ov8), .out_ready(ordy8), .Sum(sum8), .C_out(co8),
    .overflow(of8));

  logic        ov_m, ir_m, co_m, of_m;
  logic [15:0] sum_m;

  always_comb begin
    ov_m = ov16; ir_m = ir16; co_m = co16; of_m = of16; sum_m = sum16;
    case (sel)
      1: begin ov_m = ov1; ir_m = ir1; co_m = co1; of_m = of1; sum_m = {15'd0, sum1}; end
      2: begin ov_m = ov8; ir_m = ir8; co_m = co8; of_m = of8; sum_m = {8'd0, sum8}; end
      default: begin end
    endcase
  end

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input int s, input logic v, input logic [15:0] ai,
                       input logic [15:0] bi, input logic ci);
    case (s)
      0: begin iv16 = v; a16 = ai; b16 = bi; c16 = ci; end
      1: begin iv1 = v; a1 = ai[0:0]; b1 = bi[0:0]; c1 = ci; end
      default: begin iv8 = v; a8 = ai[7:0]; b8 = bi[7:0]; c8 = ci; end
    endcase
  endtask

  // Issue one operation and wait (bounded) for out_valid; operands are scrambled after accept.
  task automatic op(input int s, input logic [15:0] ai, input logic [15:0] bi,
                    input logic ci, input int exp_lat);
    logic [15:0] prev;
    int lat;
    sel = s;
    @(negedge clk);
    prev = sum_m;
    chk("in_ready_idle", {31'd0, ir_m}, 32'd1);
    drive(s, 1'b1, ai, bi, ci);
    @(posedge clk); #1;
    drive(s, 1'b0, ~ai, ~bi, ~ci);
    lat = 0;
    while (!ov_m && lat < 40) begin
      chk("sum_hold_run", {16'd0, sum_m}, {16'd0, prev});
      chk("in_ready_busy", {31'd0, ir_m}, 32'd0);
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, exp_lat);
  endtask

  task automatic chk_result(input logic [15:0] es, input logic ec, input logic eo);
    chk("sum", {16'd0, sum_m}, {16'd0, es});
    chk("c_out", {31'd0, co_m}, {31'd0, ec});
    chk("overflow", {31'd0, of_m}, {31'd0, eo});
  endtask

  // With out_ready high, out_valid must drop after exactly one cycle.
  task automatic chk_release();
    @(posedge clk); #1;
    chk("out_valid_pulse", {31'd0, ov_m}, 32'd0);
    chk("in_ready_after", {31'd0, ir_m}, 32'd1);
  endtask

  initial begin
    vecs[0] = '{16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{16'h8000, 16'h8000, 1'b1, 16'h0001, 1'b1, 1'b1};
    vecs[4] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
    vecs[5] = '{16'h0F0F, 16'h00F1, 1'b1, 16'h1001, 1'b0, 1'b0};
    vecs[6] = '{16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1};
    vecs[7] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};

    rst_n = 1'b0;
    drive(0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    drive(1, 1'b0, 16'h0000, 16'h0000, 1'b0);
    drive(2, 1'b0, 16'h0000, 16'h0000, 1'b0);
    ordy16 = 1'b1; ordy1 = 1'b1; ordy8 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, ov16}, 32'd0);
    chk("rst_in_ready", {31'd0, ir16}, 32'd1);
    chk("rst_sum", {16'd0, sum16}, 32'd0);
    chk("rst_c_out", {31'd0, co16}, 32'd0);
    chk("rst_overflow", {31'd0, of16}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Main table, 16/4: four digit cycles each.
    for (int i = 0; i < 8; i++) begin
      op(0, vecs[i].a, vecs[i].b, vecs[i].cin, 4);
      chk_result(vecs[i].sum, vecs[i].cout, vecs[i].ovf);
      chk_release();
    end

    // Back-pressure: result held, in_valid ignored while DONE.
    ordy16 = 1'b0;
    op(0, 16'h0003, 16'h0004, 1'b0, 4);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drive(0, 1'b1, 16'hAAAA, 16'h1111, 1'b1);
      @(posedge clk); #1;
      drive(0, 1'b0, 16'h0000, 16'h0000, 1'b0);
      chk("hold_out_valid", {31'd0, ov16}, 32'd1);
      chk("hold_sum", {16'd0, sum16}, 32'h0007);
      chk("hold_in_ready", {31'd0, ir16}, 32'd0);
    end
    @(negedge clk);
    ordy16 = 1'b1;
    @(posedge clk); #1;
    chk("release_out_valid", {31'd0, ov16}, 32'd0);
    chk("release_in_ready", {31'd0, ir16}, 32'd1);
    chk("idle_sum_kept", {16'd0, sum16}, 32'h0007);
    @(posedge clk); #1;
    chk("no_queued_accept", {31'd0, ir16}, 32'd1);

    // Reset two cycles into RUN discards the operation.
    sel = 0;
    @(negedge clk);
    drive(0, 1'b1, 16'h00FF, 16'h0F00, 1'b0);
    @(posedge clk); #1;
    drive(0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrun_rst_out_valid", {31'd0, ov16}, 32'd0);
    chk("midrun_rst_in_ready", {31'd0, ir16}, 32'd1);
    chk("midrun_rst_sum", {16'd0, sum16}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_held_out_valid", {31'd0, ov16}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    op(0, 16'h1234, 16'h4321, 1'b0, 4);
    chk_result(16'h5555, 1'b0, 1'b0);
    chk_release();

    // 1-bit instance: full-adder truth table with single-cycle RUN.
    for (int i = 0; i < 8; i++) begin
      logic [2:0] bits;
      logic [1:0] tot;
      bits = 3'(i);
      tot  = 2'(bits[2]) + 2'(bits[1]) + 2'(bits[0]);
      op(1, {15'd0, bits[2]}, {15'd0, bits[1]}, bits[0], 1);
      chk_result({15'd0, tot[0]}, tot[1], bits[0] ^ tot[1]);
      chk_release();
    end

    // 8-bit instance with DIGIT == WIDTH.
    op(2, 16'h00FF, 16'h0001, 1'b0, 1);
    chk_result(16'h0000, 1'b1, 1'b0);
    chk_release();
    op(2, 16'h007F, 16'h0001, 1'b0, 1);
    chk_result(16'h0080, 1'b0, 1'b1);
    chk_release();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
